// File: rtl/bus_arbiter_pkg.sv
// Shared types and select encoding for the operand-bus arbiter.
// Holds the FSM state enum and the index-to-select-code helper.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] SEL_IDLE = 4'd0;

    function automatic logic [SEL_W-1:0] sel_code(
        input logic [SEL_W-1:0] idx
    );
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the cores and the operand-bus arbiter.
// timeout_err exists only when ARB_TIMEOUT_EN is defined.
interface bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import bus_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   select;
    logic               busy;

`ifdef ARB_TIMEOUT_EN
    logic timeout_err;

    modport master (
        output req, done,
        input  grant, select, busy, timeout_err
    );
    modport slave (
        input  req, done,
        output grant, select, busy, timeout_err
    );
`else
    modport master (
        output req, done,
        input  grant, select, busy
    );
    modport slave (
        input  req, done,
        output grant, select, busy
    );
`endif

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester found at or after ptr wins.
// Purely combinational; ptr must be below NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         ptr,
    output logic [3:0]         winner,
    output logic               valid
);

    logic [4:0]         idx;
    logic [NUM_REQ-1:0] shr;

    always_comb begin
        valid  = 1'b0;
        winner = 4'd0;
        idx    = 5'd0;
        shr    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            // wrap past the last requester back to index 0
            if (idx >= 5'(NUM_REQ)) begin
                idx = idx - 5'(NUM_REQ);
            end
            shr = req >> idx;
            if (!valid && shr[0]) begin
                valid  = 1'b1;
                winner = idx[3:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit operand bus (IDLE/GRANT/RELEASE).
// Define ARB_TIMEOUT_EN to add the MAX_HOLD forced release and timeout_err.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 16
) (
    input logic         clk,
    input logic         rst_n,
    bus_arbiter_if.slave bus
);

    arb_state_t state, state_nx;
    logic [3:0] ptr, ptr_nx;
    logic [3:0] owner, owner_nx;
    logic [3:0] winner;
    logic       win_valid;
    logic       release_req;
    logic       timeout_hit;
    logic [NUM_REQ-1:0] own_mask;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .winner(winner),
        .valid (win_valid)
    );

    assign own_mask    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
    assign release_req = (|(bus.done & own_mask)) | ~(|(bus.req & own_mask));

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold;
    logic          tmo;

    assign timeout_hit = (hold == CW'(MAX_HOLD - 1));

    // hold counts completed GRANT cycles; cleared whenever not granting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            tmo  <= 1'b0;
        end else begin
            hold <= (state == GRANT) ? hold + 1'b1 : '0;
            tmo  <= (state == GRANT) && !release_req && timeout_hit;
        end
    end

    assign bus.timeout_err = tmo;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 4'd0;
            owner <= 4'd0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            owner <= owner_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nx = GRANT;
                    owner_nx = winner;
                end
            end
            GRANT: begin
                if (release_req || timeout_hit) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                ptr_nx   = (owner == 4'(NUM_REQ - 1)) ? 4'd0 : owner + 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.grant  = (state == GRANT) ? own_mask : '0;
    assign bus.select = (state == GRANT) ? sel_code(owner) : SEL_IDLE;
    assign bus.busy   = |bus.grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic vs a
// behavioural round-robin model; covers ARB_TIMEOUT_EN when defined.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_REQ(N)) bus ();

    bus_arbiter #(
        .NUM_REQ (N),
        .MAX_HOLD(MH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: owner index or -1, one-cycle gap after each release
    int m_owner;
    int m_last;
    int m_ptr;
    int m_hold;
    bit m_gap;
    bit m_terr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_gap   = 1'b0;
        m_terr  = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        int idx;
        m_terr = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_ptr = (m_last + 1) % N;
        end else if (m_owner >= 0) begin
            m_hold++;
            if (bus.done[m_owner] || !bus.req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_hold == MH) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
                m_terr  = 1'b1;
            end
`endif
        end else begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr + i) % N;
                if (!found && bus.req[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_hold  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("select", 32'(bus.select), 32'(m_owner + 1));
        chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
`ifdef ARB_TIMEOUT_EN
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_grant(input string tag);
        int k;
        k = 0;
        while (m_owner < 0 && k < 20) begin
            cyc();
            k++;
        end
        if (m_owner < 0) begin
            checks++;
            errors++;
            $error("FAIL %s no grant within 20 cycles", tag);
        end
    endtask

    task automatic pulse_done(input logic [N-1:0] d, input logic [N-1:0] r);
        bus.done = d;
        bus.req  = r;
        cyc();
        bus.done = '0;
    endtask

    initial begin
        int pulses;
        bus.req  = '0;
        bus.done = '0;
        model_reset();

        #2;
        check_all();
        cyc();

        // first arbitration on the first edge with rst_n high
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b0001;
        cyc();
        chk("s028_sel", 32'(bus.select), 32'd1);
        pulse_done(4'b0001, 4'b0000);
        chk("s028_gap", 32'(bus.select), 32'd0);
        cyc();
        cyc();

        // two requesters held, done two cycles after each grant
        bus.req = 4'b0011;
        for (int g = 0; g < 6; g++) begin
            wait_grant("s029_wait");
            if (m_owner == 0) begin
                bus.done = 4'b0010;
                cyc();
                bus.done = '0;
                chk("s033_keep", 32'(bus.grant), 32'h1);
            end else begin
                cyc();
            end
            pulse_done(4'b0001 << m_owner, 4'b0011);
        end
        bus.req = '0;
        cyc();
        cyc();

        // steer ptr to 3, then check wrap to requester 0
        bus.req = 4'b0100;
        wait_grant("s030_pre");
        pulse_done(4'b0100, 4'b0000);
        cyc();
        bus.req = 4'b1001;
        wait_grant("s030_first");
        chk("s030_sel3", 32'(bus.select), 32'd4);
        pulse_done(4'b1000, 4'b0001);
        wait_grant("s030_wrap");
        chk("s030_sel0", 32'(bus.select), 32'd1);
        pulse_done(4'b0001, 4'b0000);
        cyc();
        cyc();

        // asynchronous reset while requester 1 holds the bus
        bus.req = 4'b0010;
        wait_grant("s031_pre");
        chk("s031_sel2", 32'(bus.select), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc();
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b0001;
        cyc();
        chk("s031_after", 32'(bus.select), 32'd1);

`ifdef ARB_TIMEOUT_EN
        // requester 0 never releases; requester 1 waits behind it
        bus.req = 4'b0011;
        pulses  = 0;
        for (int c = 0; c < 24; c++) begin
            cyc();
            if (bus.timeout_err === 1'b1) pulses++;
        end
        chk("s032_pulses", 32'(pulses), 32'd1);
        chk("s032_owner1", 32'(bus.select), 32'd2);
`else
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            cyc();
            if (bus.grant !== 4'b0001) pulses++;
        end
        chk("hold_forever", 32'(pulses), 32'd0);
`endif
        bus.req = '0;
        cyc();
        cyc();
        cyc();

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) bus.req = N'($urandom);
            bus.done = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
